load_store_unit: RTL and testbench

//  CPU-side initiator for the byte-addressed, little-endian data memory: A/WD/WE out, RD in.
//  - Memory reads combinationally and always returns the 4 bytes at A..A+3.
//  - Memory writes all 4 bytes on the clock edge when WE is high.
//  - Accepts one load/store from the execute/memory stage per handshake.
//  - Loads: always issues word-aligned addresses, extracts the byte/half lane, then sign- or zero-extends it.
//  - Sub-word stores: done as read-modify-write, because memory has no byte enables.
//  - Reports misaligned, out-of-range and illegal-funct3 accesses as errors.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for a byte-addressed little-endian memory with no byte enables.
// Loads are issued word-aligned; sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int                WIDTH   = 32,
    parameter logic [WIDTH-1:0]  MEM_TOP = 32'h1FFFF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    input  logic [WIDTH-1:0] mem_RD
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [1:0]       span_lo;
    logic [WIDTH:0]   last_byte;
    logic             misaligned, out_of_range, illegal, req_err;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [WIDTH-1:0] load_data, store_word, aligned_addr;

    // The range check is one bit wider so an address near the top of the space cannot wrap.
    always_comb begin
        span_lo = 2'd3;
        case (req_funct3[1:0])
            2'b00:   span_lo = 2'd0;
            2'b01:   span_lo = 2'd1;
            default: span_lo = 2'd3;
        endcase
        last_byte    = {1'b0, req_addr} + {{(WIDTH-1){1'b0}}, span_lo};
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = last_byte > {1'b0, MEM_TOP};
        illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
        req_err      = misaligned || out_of_range || illegal;
    end

    always_comb begin
        aligned_addr = {addr_q[WIDTH-1:2], 2'b00};
        lane_b       = mem_RD[{addr_q[1:0], 3'b000} +: 8];
        lane_h       = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        load_data    = mem_RD;
        case (funct3_q)
            F3_B:    load_data = {{(WIDTH-8){lane_b[7]}}, lane_b};
            F3_BU:   load_data = {{(WIDTH-8){1'b0}}, lane_b};
            F3_H:    load_data = {{(WIDTH-16){lane_h[15]}}, lane_h};
            F3_HU:   load_data = {{(WIDTH-16){1'b0}}, lane_h};
            F3_W:    load_data = mem_RD;
            default: load_data = mem_RD;
        endcase
        // Sub-word stores patch the word captured in RMW_RD.
        store_word = word_q;
        case (funct3_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    rdata_d  = '0;
                    if (req_err)
                        state_d = RESP;
                    else if (!req_we)
                        state_d = LOAD;
                    else if (req_funct3 == F3_W)
                        state_d = STORE;
                    else
                        state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RMW_RD: begin
                word_d  = mem_RD;
                state_d = STORE;
            end
            STORE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Write enable is gated by reset so an aborted store never reaches memory.
    assign req_ready  = (state_q == IDLE) && !RST;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign mem_A      = ((state_q != IDLE) && !err_q) ? aligned_addr : '0;
    assign mem_WE     = (state_q == STORE) && we_q && !RST;
    assign mem_WD     = (state_q == STORE) ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural memory, vector table, scoreboard of expected responses,
// plus hand-written reset-abort and back-to-back sequences.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] mem [0:32767];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          we_count = 0;
    logic [31:0] last_wd, last_wa;

    load_store_unit dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign mem_RD = mem[mem_A[16:2]];
    always @(posedge CLK) if (mem_WE) mem[mem_A[16:2]] <= mem_WD;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responses are matched in order against the scoreboard; latency is counted from the accept edge.
    always @(negedge CLK) begin
        if (mem_WE) begin
            we_count++;
            last_wd = mem_WD;
            last_wa = mem_A;
        end
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_output("resp_rdata", resp_rdata, mon_e.rdata);
                check_output("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
                check_output("resp_latency", cyc + 1 - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                           input int lat, input logic [31:0] wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.wd = wd;
        vecs.push_back(v);
    endtask

    task automatic wait_response();
        int g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(posedge CLK);
            g++;
        end
        check_output("resp_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input vec_t v);
        int g = 0;
        int we0;
        logic [31:0] aligned;
        we0 = we_count;
        aligned = {v.addr[31:2], 2'b00};
        @(negedge CLK);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        while (!req_ready && g < 20) begin
            @(negedge CLK);
            g++;
        end
        check_output("accept_ready", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        push_exp(v.rdata, v.err, v.lat);
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        @(negedge CLK);
        check_output("mem_A_first", mem_A, v.err ? 32'd0 : aligned);
        wait_response();
        check_output("we_cycles", we_count - we0, (v.we && !v.err) ? 32'd1 : 32'd0);
        if (v.we && !v.err) begin
            check_output("store_WD", last_wd, v.wd);
            check_output("store_A", last_wa, aligned);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int we0;
        int acc1;
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        mem[15'h4000] = 32'h8899AABB;
        mem[15'h7FFF] = 32'hCAFEF00D;
        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        //      we    f3      addr          wdata         rdata         err  lat wd
        add_vec(1'b0, 3'b000, 32'h00010003, 32'h0,        32'hFFFFFF88, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b100, 32'h00010003, 32'h0,        32'h00000088, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b101, 32'h00010002, 32'h0,        32'h00008899, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b010, 32'h00010000, 32'h0,        32'h8899AABB, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b001, 32'h00010000, 32'h0,        32'hFFFFAABB, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b000, 32'h00010001, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b100, 32'h00010002, 32'h0,        32'h00000099, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b001, 32'h00010001, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b1, 3'b010, 32'h00020000, 32'h11111111, 32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b0, 3'b010, 32'h00010002, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b0, 3'b010, 32'h0001FFFC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b100, 32'h0001FFFF, 32'h0,        32'h000000CA, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b001, 32'h0001FFFE, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b000, 32'h00020000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b0, 3'b011, 32'h00010000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b1, 3'b100, 32'h00010000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b0, 3'b111, 32'h00010000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b1, 3'b101, 32'h00010000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b0, 3'b110, 32'h00010000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b1, 3'b000, 32'h00010001, 32'h12345677, 32'h0,        1'b0, 3, 32'h889977BB);
        add_vec(1'b0, 3'b010, 32'h00010000, 32'h0,        32'h889977BB, 1'b0, 2, 32'h0);
        add_vec(1'b1, 3'b001, 32'h00010002, 32'hDEADBEEF, 32'h0,        1'b0, 3, 32'hBEEF77BB);
        add_vec(1'b0, 3'b010, 32'h00010000, 32'h0,        32'hBEEF77BB, 1'b0, 2, 32'h0);
        add_vec(1'b0, 3'b101, 32'h00010002, 32'h0,        32'h0000BEEF, 1'b0, 2, 32'h0);
        add_vec(1'b1, 3'b000, 32'h00010003, 32'h00000055, 32'h0,        1'b0, 3, 32'h55EF77BB);
        add_vec(1'b0, 3'b000, 32'h00010003, 32'h0,        32'h00000055, 1'b0, 2, 32'h0);
        add_vec(1'b1, 3'b010, 32'h00010000, 32'h8899AABB, 32'h0,        1'b0, 2, 32'h8899AABB);
        add_vec(1'b1, 3'b000, 32'h00010000, 32'hFFFFFFFF, 32'h0,        1'b0, 3, 32'h8899AAFF);
        add_vec(1'b0, 3'b000, 32'h00010000, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 32'h0);
        add_vec(1'b1, 3'b010, 32'h00010000, 32'h8899AABB, 32'h0,        1'b0, 2, 32'h8899AABB);
        add_vec(1'b1, 3'b001, 32'h00010001, 32'h0000FFFF, 32'h0,        1'b1, 1, 32'h0);
        add_vec(1'b1, 3'b010, 32'h0001FFFD, 32'h0000FFFF, 32'h0,        1'b1, 1, 32'h0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_mem_A", mem_A, 32'd0);
        check_output("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
        check_output("rst_mem_WD", mem_WD, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_output("ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        // Reset during RMW_RD of an SH: aborted with no write and no response.
        we0 = we_count;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h00010002; req_wdata = 32'h1234ABCD;
        @(posedge CLK); #1;
        req_valid = 1'b0; RST = 1'b1;
        @(negedge CLK);
        check_output("rmw_rst_ready", {31'd0, req_ready}, 32'd0);
        check_output("rmw_rst_WE", {31'd0, mem_WE}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_output("rmw_rst_idle", {31'd0, req_ready}, 32'd1);
        check_output("rmw_rst_mem_A", mem_A, 32'd0);
        repeat (3) @(negedge CLK);
        check_output("rmw_rst_we_cycles", we_count - we0, 32'd0);
        check_output("rmw_rst_mem", mem[15'h4000], 32'h8899AABB);

        // Reset during the STORE cycle of an SB: the write must be suppressed.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h00010000; req_wdata = 32'h00000011;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check_output("store_rst_WE", {31'd0, mem_WE}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("store_rst_we_cycles", we_count - we0, 32'd0);
        check_output("store_rst_mem", mem[15'h4000], 32'h8899AABB);
        apply_stimulus(vecs[3]);

        // Back-to-back LW then SW with req_valid held; the SW fields appear while the LW is busy.
        we0 = we_count;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h00010000; req_wdata = 32'h0;
        @(posedge CLK); #1;
        acc1 = cyc;
        push_exp(32'h8899AABB, 1'b0, 2);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h00010000; req_wdata = 32'h8899AABB;
        @(negedge CLK);
        check_output("b2b_busy1", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        check_output("b2b_busy2", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        check_output("b2b_ready", {31'd0, req_ready}, 32'd1);
        @(posedge CLK); #1;
        check_output("b2b_accept_cycle", cyc - acc1, 32'd3);
        push_exp(32'h0, 1'b0, 2);
        req_valid = 1'b0;
        wait_response();
        check_output("b2b_we_cycles", we_count - we0, 32'd1);
        check_output("b2b_WD", last_wd, 32'h8899AABB);

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
